// File: rtl/aes_pkg.sv
// Shared AES decrypt definitions: FSM state enum, round-counter width, legal
// key-size configurations and the GF(2^8) byte/state transforms.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXPAND = 3'd1,
    ADDKEY = 3'd2,
    ROUND  = 3'd3,
    FINAL  = 3'd4,
    DONE   = 3'd5
  } dec_state_e;

  function automatic int round_w(input int nr);
    return $clog2(nr + 1);
  endfunction

  function automatic bit legal_cfg(input int n, input int nk, input int nr);
    return (n == 128 && nk == 4 && nr == 10) ||
           (n == 192 && nk == 6 && nr == 12) ||
           (n == 256 && nk == 8 && nr == 14);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // State byte k (column k/4, row k%4) lives at bits [127-8k -: 8].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++)
      o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'd14) ^ gf_mul(a1, 8'd11) ^ gf_mul(a2, 8'd13) ^ gf_mul(a3, 8'd9);
      o[119-32*c -: 8] = gf_mul(a0, 8'd9)  ^ gf_mul(a1, 8'd14) ^ gf_mul(a2, 8'd11) ^ gf_mul(a3, 8'd13);
      o[111-32*c -: 8] = gf_mul(a0, 8'd13) ^ gf_mul(a1, 8'd9)  ^ gf_mul(a2, 8'd14) ^ gf_mul(a3, 8'd11);
      o[103-32*c -: 8] = gf_mul(a0, 8'd11) ^ gf_mul(a1, 8'd13) ^ gf_mul(a2, 8'd9)  ^ gf_mul(a3, 8'd14);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_dec_round_step.sv
// Shared inverse-round datapath: picks the initial key add, a middle inverse
// round or the final round (no InvMixColumns) for the current FSM phase.
module aes_dec_round_step
  import aes_pkg::*;
(
    input  logic [127:0] data,
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         addkey,
    input  logic         last_round,
    output logic [127:0] next_state
);

    logic [127:0] keyed;

    always_comb begin
        keyed = inv_sub_bytes(inv_shift_rows(state)) ^ rk;
        if (addkey)
            next_state = data ^ rk;
        else if (last_round)
            next_state = keyed;
        else
            next_state = inv_mix_columns(keyed);
    end

endmodule

// File: rtl/aes_decrypt_sequencer.sv
// Round-serial AES inverse cipher controller. Optional completed-block counter
// output blk_count is enabled by defining AES_DEC_BLKCNT_EN.
module aes_decrypt_sequencer
  import aes_pkg::*;
#(
    parameter int N  = 128,
    parameter int Nr = 10,
    parameter int Nk = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [N-1:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [2:0]   fsm_state
`ifdef AES_DEC_BLKCNT_EN
    ,
    output logic [31:0]  blk_count
`endif
);

    localparam int RW = round_w(Nr);
    localparam int NW = 4 * (Nr + 1);
    localparam int SW = 128 * (Nr + 1);

    if (!legal_cfg(N, Nk, Nr)) begin : g_bad_cfg
        $error("aes_decrypt_sequencer: unsupported (N, Nk, Nr) combination");
    end

    dec_state_e      fsm_q, fsm_d;
    logic [127:0]    data_q;
    logic [N-1:0]    key_q;
    logic [SW-1:0]   sched_q, sched_d;
    logic [127:0]    state_q, step_out, rk;
    logic [RW-1:0]   round_q;
    logic [31:0]     w [NW];
    logic [31:0]     tmp;
    logic [7:0]      rc;
    int              rk_idx;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a producer holds valid and its data stable until that edge.
    assign in_ready  = rst_n && (fsm_q == IDLE);
    assign busy      = (fsm_q != IDLE);
    assign out_valid = (fsm_q == DONE);
    assign out_data  = out_valid ? state_q : '0;
    assign fsm_state = fsm_q;

    always_ff @(posedge clk) begin
        if (!rst_n) fsm_q <= IDLE;
        else        fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (in_valid) fsm_d = EXPAND;
            EXPAND:  fsm_d = ADDKEY;
            ADDKEY:  fsm_d = ROUND;
            ROUND:   if (round_q == RW'(Nr - 1)) fsm_d = FINAL;
            FINAL:   fsm_d = DONE;
            DONE:    if (out_ready) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        rc  = 8'h01;
        tmp = '0;
        for (int i = 0; i < Nk; i++)
            w[i] = key_q[N-1-32*i -: 32];
        for (int i = Nk; i < NW; i++) begin
            tmp = w[i-1];
            if (i % Nk == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xtime(rc);
            end else if (Nk > 6 && i % Nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-Nk] ^ tmp;
        end
    end

    // Stored in inverse-cipher order: slot i holds encryption round key Nr-i.
    always_comb begin
        sched_d = '0;
        for (int r = 0; r <= Nr; r++)
            sched_d[128*(Nr-r) +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end

    always_comb begin
        rk_idx = 0;
        if (fsm_q == ROUND)      rk_idx = int'(round_q);
        else if (fsm_q == FINAL) rk_idx = Nr;
        rk = sched_q[128*rk_idx +: 128];
    end

    aes_dec_round_step u_step (
        .data       (data_q),
        .state      (state_q),
        .rk         (rk),
        .addkey     (fsm_q == ADDKEY),
        .last_round (fsm_q == FINAL),
        .next_state (step_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            key_q   <= '0;
            sched_q <= '0;
            state_q <= '0;
            round_q <= '0;
        end else begin
            case (fsm_q)
                IDLE: if (in_valid) begin
                    data_q  <= in_data;
                    key_q   <= in_key;
                    round_q <= '0;
                end
                EXPAND: sched_q <= sched_d;
                ADDKEY: begin
                    state_q <= step_out;
                    round_q <= RW'(1);
                end
                ROUND: begin
                    state_q <= step_out;
                    round_q <= round_q + RW'(1);
                end
                FINAL:   state_q <= step_out;
                default: ;
            endcase
        end
    end

`ifdef AES_DEC_BLKCNT_EN
    logic [31:0] blk_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n)                      blk_count_q <= '0;
        else if (out_valid && out_ready) blk_count_q <= blk_count_q + 32'd1;
    end

    assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// Self-checking bench for aes_decrypt_sequencer (AES-128 and AES-256 instances);
// expected plaintexts come from FIPS-197 vectors and a forward-cipher model.
module tb_aes_decrypt_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT signals ----------------
  logic         in_valid_a = 0, in_ready_a, out_valid_a, out_ready_a = 0, busy_a;
  logic [127:0] in_data_a = '0, in_key_a = '0, out_data_a;
  logic [2:0]   fsm_state_a;
  logic         in_valid_b = 0, in_ready_b, out_valid_b, out_ready_b = 0, busy_b;
  logic [127:0] in_data_b = '0, out_data_b;
  logic [255:0] in_key_b = '0;
  logic [2:0]   fsm_state_b;
`ifdef AES_DEC_BLKCNT_EN
  logic [31:0]  blk_count_a, blk_count_b;
`endif

  aes_decrypt_sequencer #(.N(128), .Nr(10), .Nk(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .in_key(in_key_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_data(out_data_a), .busy(busy_a),
    .fsm_state(fsm_state_a)
`ifdef AES_DEC_BLKCNT_EN
    , .blk_count(blk_count_a)
`endif
  );

  aes_decrypt_sequencer #(.N(256), .Nr(14), .Nk(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .in_key(in_key_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .busy(busy_b),
    .fsm_state(fsm_state_b)
`ifdef AES_DEC_BLKCNT_EN
    , .blk_count(blk_count_b)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [127:0] exp_q_a[$];
  logic [127:0] exp_q_b[$];
  int           acc_q_a[$];
  int           acc_q_b[$];
  bit           prev_va = 0, prev_vb = 0;
  bit           bp_rand = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // ---------------- reference model: forward AES cipher ----------------
  logic [7:0] sbox_m [256];

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // Builds the S-box by walking generator 3 and its inverse in lockstep.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sbox_m[p] = x ^ 8'h63;
    end
    sbox_m[0] = 8'h63;
  endtask

  // key is left-aligned: byte i of the cipher key is key[255-8i -: 8].
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [255:0] key, input int nk);
    int nr;
    logic [7:0] w [60][4];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] res;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++)
      for (int j = 0; j < 4; j++) w[i][j] = key[255-8*(4*i+j) -: 8];
    for (int i = nk; i < 4*(nr+1); i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
      if (i % nk == 0) begin
        a0 = tmp[0];
        tmp[0] = sbox_m[tmp[1]] ^ rc;
        tmp[1] = sbox_m[tmp[2]];
        tmp[2] = sbox_m[tmp[3]];
        tmp[3] = sbox_m[a0];
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        for (int j = 0; j < 4; j++) tmp[j] = sbox_m[tmp[j]];
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-nk][j] ^ tmp[j];
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][k%4];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) t[k] = sbox_m[s[4*((k/4 + k%4) % 4) + k%4]];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int k = 0; k < 16; k++) s[k] = t[k] ^ w[4*r + k/4][k%4];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst_n) prev_va = 0;
    else begin
      if (out_valid_a && !prev_va) begin
        if (acc_q_a.size() == 0) fail_now("a_unexpected_valid");
        else check("a_latency", 256'(cyc - acc_q_a[0]), 256'(12));
      end
      if (out_valid_a && out_ready_a) begin
        if (exp_q_a.size() == 0) fail_now("a_unexpected_handshake");
        else begin
          check("a_data", {128'h0, out_data_a}, {128'h0, exp_q_a.pop_front()});
          void'(acc_q_a.pop_front());
        end
      end
      prev_va = out_valid_a;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) prev_vb = 0;
    else begin
      if (out_valid_b && !prev_vb) begin
        if (acc_q_b.size() == 0) fail_now("b_unexpected_valid");
        else check("b_latency", 256'(cyc - acc_q_b[0]), 256'(16));
      end
      if (out_valid_b && out_ready_b) begin
        if (exp_q_b.size() == 0) fail_now("b_unexpected_handshake");
        else begin
          check("b_data", {128'h0, out_data_b}, {128'h0, exp_q_b.pop_front()});
          void'(acc_q_b.pop_front());
        end
      end
      prev_vb = out_valid_b;
    end
  end

  always @(posedge clk) begin
    if (bp_rand) begin
      #1;
      out_ready_a = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_a(input logic [127:0] ct, input logic [127:0] key,
                        input logic [127:0] pt, input bit track, output int acc);
    int n;
    in_data_a = ct; in_key_a = key; in_valid_a = 1; n = 0;
    @(negedge clk);
    while (!in_ready_a && n < 200) begin @(negedge clk); n++; end
    if (!in_ready_a) begin
      fail_now("a_accept_timeout");
      in_valid_a = 0; acc = -1;
      return;
    end
    acc = cyc + 1;
    if (track) begin exp_q_a.push_back(pt); acc_q_a.push_back(acc); end
    @(posedge clk); #1;
    in_valid_a = 0; in_data_a = rand128(); in_key_a = rand128();
  endtask

  task automatic send_b(input logic [127:0] ct, input logic [255:0] key, input logic [127:0] pt);
    int n;
    in_data_b = ct; in_key_b = key; in_valid_b = 1; n = 0;
    @(negedge clk);
    while (!in_ready_b && n < 200) begin @(negedge clk); n++; end
    if (!in_ready_b) begin
      fail_now("b_accept_timeout");
      in_valid_b = 0;
      return;
    end
    exp_q_b.push_back(pt); acc_q_b.push_back(cyc + 1);
    @(posedge clk); #1;
    in_valid_b = 0; in_data_b = rand128(); in_key_b = {rand128(), rand128()};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && n < 1000) begin
      @(negedge clk); n++;
    end
    if (exp_q_a.size() != 0 || exp_q_b.size() != 0) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
  endtask

  // ---------------- main sequence ----------------
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    int acc0, acc1, acc2, n;
    logic [127:0] pt, key;
    logic [255:0] key256;
    build_sbox();

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_low", {255'h0, in_ready_a}, 256'h0);
    check("rst_out_valid", {255'h0, out_valid_a}, 256'h0);
    check("rst_busy", {255'h0, busy_a}, 256'h0);
    check("rst_out_data", {128'h0, out_data_a}, 256'h0);
    check("rst_b_in_ready_low", {255'h0, in_ready_b}, 256'h0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("post_rst_in_ready", {255'h0, in_ready_a}, 256'h1);
    check("post_rst_b_in_ready", {255'h0, in_ready_b}, 256'h1);
`ifdef AES_DEC_BLKCNT_EN
    check("rst_blk_count", {224'h0, blk_count_a}, 256'h0);
`endif
    @(posedge clk); #1;

    // FIPS-197 C.1 and C.3
    out_ready_a = 1; out_ready_b = 1;
    send_a(C1_CT, C1_KEY, C_PT, 1, acc0);
    send_b(C3_CT, C3_KEY, C_PT);
    drain();

    // back-pressure with the Appendix B vector
    out_ready_a = 0;
    send_a(B_CT, B_KEY, B_PT, 1, acc0);
    n = 0;
    while (!out_valid_a && n < 50) begin @(negedge clk); n++; end
    if (!out_valid_a) fail_now("bp_valid_timeout");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_valid_held", {255'h0, out_valid_a}, 256'h1);
      check("bp_data_held", {128'h0, out_data_a}, {128'h0, B_PT});
      check("bp_in_ready_low", {255'h0, in_ready_a}, 256'h0);
    end
    @(posedge clk); #1 out_ready_a = 1;
    @(posedge clk); #1;
    check("bp_in_ready_after", {255'h0, in_ready_a}, 256'h1);
    check("bp_valid_dropped", {255'h0, out_valid_a}, 256'h0);
    drain();

    // inputs change after acceptance; in_valid held high while busy
    send_a(C1_CT, C1_KEY, C_PT, 1, acc0);
    in_valid_a = 1; n = 0;
    while (n < 100) begin
      in_data_a = rand128(); in_key_a = rand128();
      @(negedge clk);
      if (!busy_a) break;
      check("busy_no_accept", {255'h0, in_ready_a}, 256'h0);
      n++;
      @(posedge clk); #1;
    end
    in_valid_a = 0;
    if (n >= 100) fail_now("busy_stuck");
    drain();

    // reset mid-job at E5: job discarded
    send_a(C1_CT, C1_KEY, C_PT, 0, acc0);
    repeat (4) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("midrst_busy", {255'h0, busy_a}, 256'h0);
    check("midrst_in_ready", {255'h0, in_ready_a}, 256'h1);
    check("midrst_out_valid", {255'h0, out_valid_a}, 256'h0);
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    send_a(C1_CT, C1_KEY, C_PT, 1, acc0);
    drain();

    // back-to-back jobs: initiation interval Nr+4
    reset_pulse();
    for (int j = 0; j < 3; j++) begin
      pt = rand128(); key = rand128();
      acc2 = acc1; acc1 = acc0;
      send_a(aes_enc(pt, {key, 128'h0}, 4), key, pt, 1, acc0);
      if (j > 0) check("interval", 256'(acc0 - acc1), 256'(14));
    end
    drain();
`ifdef AES_DEC_BLKCNT_EN
    check("blk_count_3", {224'h0, blk_count_a}, 256'h3);
    @(negedge clk);
    force dut_a.blk_count_q = 32'hFFFFFFFF;
    @(posedge clk); #1;
    release dut_a.blk_count_q;
    send_a(C1_CT, C1_KEY, C_PT, 1, acc0);
    drain();
    check("blk_count_wrap", {224'h0, blk_count_a}, 256'h0);
`endif

    // randomized jobs with random back-pressure and idle gaps
    bp_rand = 1;
    for (int j = 0; j < 8; j++) begin
      pt = rand128(); key = rand128();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_a(aes_enc(pt, {key, 128'h0}, 4), key, pt, 1, acc0);
    end
    drain();
    bp_rand = 0;
    @(posedge clk); #1 out_ready_a = 1;
    for (int j = 0; j < 3; j++) begin
      pt = rand128(); key256 = {rand128(), rand128()};
      send_b(aes_enc(pt, key256, 8), key256, pt);
    end
    drain();

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    fail_now("global_timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_sequencer.md
# aes_decrypt_sequencer

Iterative, round-serial AES inverse-cipher controller. It accepts one ciphertext block and its cipher key over a valid/ready handshake, expands the key once, and runs a single shared inverse round datapath for Nr+1 key additions. It presents the plaintext over a second valid/ready handshake. It sits in front of the existing key expansion, add-round-key, inverse-round and final-round primitives, and is the area-reduced alternative to the fully unrolled inverse cipher.

## Interface
- N, 128: cipher key width in bits (128/192/256).
- Nr, 10: number of rounds (10/12/14).
- Nk, 4: key length in 32-bit words (4/6/8).
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  ciphertext and key are valid.
- in_ready  output  1  block can accept a new job; high only in IDLE.
- in_data  input  128  ciphertext block.
- in_key  input  N  cipher key.
- out_valid  output  1  plaintext valid.
- out_ready  input  1  consumer accepts the plaintext.
- out_data  output  128  plaintext block.
- busy  output  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, EXPAND, ADDKEY, ROUND, FINAL, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_data into data_q and in_key into key_q, then go to EXPAND.
- EXPAND: register the full key schedule (128*(Nr+1) bits) from key_q. Go to ADDKEY.
- ADDKEY: state_q <= data_q ^ rk[0]; round_q <= 1. Go to ROUND.
- ROUND: state_q <= inverse round(state_q, rk[round_q]); round_q <= round_q+1. After processing round_q==Nr-1, go to FINAL.
- FINAL: state_q <= InvSubBytes(InvShiftRows(state_q)) ^ rk[Nr]. Go to DONE.
- DONE: out_valid=1 and out_data=state_q, both held stable until out_ready. On out_valid&out_ready, go to IDLE.
- Round keys are taken from the schedule in the same order as the unrolled inverse cipher: rk[i] = schedule[i*128 +: 128].
- round_q is $clog2(Nr+1) bits wide and never exceeds Nr.
- in_data and in_key are sampled only at acceptance. Changes afterwards have no effect.
- No new job is accepted in DONE, even if out_ready is high in that cycle. in_ready rises the cycle after the handshake.
- Reset values: state IDLE, in_ready=1 once reset is released (0 while rst_n is low), out_valid=0, out_data=0, busy=0, round_q=0.
- Reset mid-operation: the job is discarded, no out_valid is produced, and the FSM returns to IDLE on the next edge.

## Timing
- Accept edge E0. EXPAND is registered at E1, ADDKEY at E2, rounds 1..Nr-1 at E3..E(Nr+1), FINAL at E(Nr+2).
- out_valid is first high in the cycle after E(Nr+2): Nr+2 cycles after acceptance.
  - Nr=10: 12 cycles.
  - Nr=14: 16 cycles.
- Minimum initiation interval: Nr+4 cycles when out_ready is held high.
- out_ready low stalls in DONE indefinitely with no state change.
- Critical paths:
  - EXPAND: key expansion alone.
  - ROUND: one inverse round plus the round-key mux.

## Configuration
- AES_DEC_BLKCNT_EN defined: adds output blk_count [31:0], the number of completed output handshakes.
  - Incremented on out_valid&out_ready.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by rst_n.
- Not defined: the port and counter are absent, and all other behaviour is identical.

## Structure
- Shared package aes_pkg holds:
  - the FSM state enum;
  - the round-counter width function/constant;
  - the legal (N, Nk, Nr) triples, used by an elaboration-time parameter check.
- The existing key expansion, add-round-key, inverse shift-rows, inverse sub-bytes and inverse round modules are reused unchanged.
- One natural new sub-module, aes_dec_round_step: a combinational unit selecting between the key-add, middle-round and final-round outputs for the current state. The FSM, counters and registers stay in the top.

## Test plan
- FIPS-197 C.1, AES-128: in_key 000102030405060708090a0b0c0d0e0f, in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid exactly 12 cycles after acceptance.
- FIPS-197 C.3, Nk=8/Nr=14: in_key 000102…1e1f, in_data 8ea2b7ca516745bfeafc49904b496089 -> out_data 00112233445566778899aabbccddeeff after 16 cycles.
- Back-pressure: FIPS-197 Appendix B vector with out_ready low for 20 cycles.
  - out_data 3243f6a8885a308d313198a2e0370734 held stable throughout.
  - in_ready stays 0 throughout.
  - One handshake, then in_ready=1 the next cycle.
- Input changes after accept: flip in_data/in_key every cycle after E0 -> result still matches the C.1 plaintext. in_valid held high during busy -> no second accept until IDLE.
- Reset mid-job: assert rst_n=0 for 1 cycle at E5 -> out_valid never rises for that job, busy=0, in_ready=1 after release. The next C.1 job decrypts correctly.
- With AES_DEC_BLKCNT_EN: 3 back-to-back jobs -> blk_count=3. Counter preset via force to 0xFFFFFFFF plus one job -> blk_count=0.
